// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction store: length, big-endian payload, XOR checksum.
// Payload bytes land at BASE_ADDR upward so a 4-byte fetch at A returns {mem[A]..mem[A+3]}.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for start after reset
// S_LEN_HI | receiving word count [15:8]
// S_LEN_LO | receiving word count [7:0], range check
// S_DATA   | receiving payload bytes, one store write each
// S_CSUM   | receiving checksum byte
// S_DONE   | load finished with matching checksum
// S_ERR    | load aborted (length out of range or bad checksum)

module imem_loader #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [15:0]       words_loaded,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0]       MAX_WORDS = 32'((MEM_BYTES - BASE_ADDR) / 4);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [17:0]       bytes_left_q, bytes_left_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        sub_q, sub_d;
  logic [15:0]       words_q, words_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic        xfer;
  logic [15:0] len_full;

  // Ready is a pure function of state so the source may wait on it freely.
  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer       = byte_valid && byte_ready;
  assign len_full   = {len_hi_q, byte_in};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_hi_q     <= 8'd0;
      bytes_left_q <= 18'd0;
      ptr_q        <= BASE;
      csum_q       <= 8'd0;
      sub_q        <= 2'd0;
      words_q      <= 16'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE;
      mem_wdata_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      bytes_left_q <= bytes_left_d;
      ptr_q        <= ptr_d;
      csum_q       <= csum_d;
      sub_q        <= sub_d;
      words_q      <= words_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    bytes_left_d = bytes_left_q;
    ptr_d        = ptr_q;
    csum_d       = csum_q;
    sub_d        = sub_q;
    words_d      = words_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_LEN_HI;
          words_d  = 16'd0;
          csum_d   = 8'd0;
          ptr_d    = BASE;
          sub_d    = 2'd0;
          len_hi_d = 8'd0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = byte_in;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          bytes_left_d = {len_full, 2'b00};
          if ({16'd0, len_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = ptr_q;
          mem_wdata_d  = byte_in;
          ptr_d        = ptr_q + ADDR_W'(1);
          csum_d       = csum_q ^ byte_in;
          sub_d        = sub_q + 2'd1;
          bytes_left_d = bytes_left_q - 18'd1;
          if (sub_q == 2'd3) begin
            words_d = words_q + 16'd1;
          end
          if (bytes_left_q == 18'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;
  assign busy         = byte_ready;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);

endmodule
